// File: rtl/game_pkg.sv
// Shared constants for the Zombie game input path: button count, hit ids and
// the default debounce window, plus the fixed-priority hit arbiter.
package game_pkg;

  localparam int unsigned BTN_NUM          = 3;
  localparam logic [1:0]  HIT_BTN1         = 2'd0;
  localparam logic [1:0]  HIT_BTN2         = 2'd1;
  localparam logic [1:0]  HIT_BTN3         = 2'd2;
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  // Lowest set bit wins; returns HIT_BTN1 when nothing is pending.
  function automatic logic [1:0] lowest_pending(input logic [BTN_NUM-1:0] pend);
    logic [1:0] id;
    id = HIT_BTN1;
    if (pend[0])      id = HIT_BTN1;
    else if (pend[1]) id = HIT_BTN2;
    else if (pend[2]) id = HIT_BTN3;
    return id;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, stable level and rising-edge pulse.
// Level changes DEBOUNCE_CYCLES+2 edges after a held raw change; no backpressure (free-running).
module btn_debounce
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES does not fit the CNT_W counter");
  end

  logic             s1;
  logic             s2;
  logic             stable;
  logic             rise_q;
  logic [CNT_W-1:0] cnt;
  logic             at_limit;

  assign at_limit = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      rise_q <= 1'b0;
      cnt    <= '0;
    end else begin
      s1     <= din;
      s2     <= s1;
      rise_q <= 1'b0;
      // Any agreement with the accepted level restarts the window.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (at_limit) begin
        stable <= ~stable;
        rise_q <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = stable;
  assign rise  = rise_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions three punch buttons into clean levels, press pulses and a sticky hit queue.
// Hits are held until hit_ack; a press on an already-pending button coalesces and pulses hit_drop.
module btn_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W           = 19,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  output logic       btn1,
  output logic       btn2,
  output logic       btn3,
  output logic [2:0] press,
  output logic       hit_valid,
  output logic [1:0] hit_id,
  input  logic       hit_ack,
  output logic       hit_drop
);

  logic [BTN_NUM-1:0] btn_in;
  logic [BTN_NUM-1:0] level;
  logic [BTN_NUM-1:0] pending;
  logic [BTN_NUM-1:0] ack_mask;

  assign btn_in = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .din  (btn_in[i]),
      .level(level[i]),
      .rise (press[i])
    );
  end

  assign btn1 = level[0];
  assign btn2 = level[1];
  assign btn3 = level[2];

  assign hit_valid = |pending;
  assign hit_id    = lowest_pending(pending);
  assign ack_mask  = (hit_ack && hit_valid) ? (BTN_NUM'(1) << hit_id) : '0;
  assign hit_drop  = |(press & pending & ~ack_mask);

  // A press in the same cycle as its own ack re-arms the bit, so it is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~ack_mask) | press;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner (DEBOUNCE_CYCLES=4): reset table, directed corner sequences,
// then random buttons/acks against a sliding-window reference model; ACTIVE_LOW copy sees inverted raw.
module tb_btn_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] btn_raw_n;
  logic       hit_ack;

  logic       btn1, btn2, btn3, hit_valid, hit_drop;
  logic [2:0] press;
  logic [1:0] hit_id;
  logic       al_btn1, al_btn2, al_btn3, al_hit_valid, al_hit_drop;
  logic [2:0] al_press;
  logic [1:0] al_hit_id;

  assign btn_raw_n = ~btn_raw;

  always #5 clk = ~clk;

  btn_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn1(btn1), .btn2(btn2), .btn3(btn3), .press(press),
    .hit_valid(hit_valid), .hit_id(hit_id), .hit_ack(hit_ack), .hit_drop(hit_drop)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .btn_raw(btn_raw_n),
    .btn1(al_btn1), .btn2(al_btn2), .btn3(al_btn3), .press(al_press),
    .hit_valid(al_hit_valid), .hit_id(al_hit_id), .hit_ack(hit_ack), .hit_drop(al_hit_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw history per edge, last toggle edge per channel, pending set.
  bit [2:0] rh[64];
  int       edge_n = 100;
  int       last_t[3];
  bit [2:0] m_stable, m_press, m_pend;

  logic [2:0] s_btn, s_press;
  logic       s_valid, s_drop;
  logic [1:0] s_id;
  int         drop_cnt, press_cnt;

  typedef struct {
    logic       r;
    logic [2:0] raw;
    logic       a;
    logic [2:0] e_btn;
    logic [2:0] e_press;
    logic       e_valid;
    logic [1:0] e_id;
    logic       e_drop;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [2:0] low_mask(input bit [2:0] p);
    for (int i = 0; i < 3; i++) if (p[i]) return 3'(1 << i);
    return 3'b000;
  endfunction

  function automatic int low_id(input bit [2:0] p);
    for (int i = 0; i < 3; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic check_inst(input string tag, input logic [2:0] bt, input logic [2:0] pr,
                            input logic v, input logic [1:0] id, input logic dr);
    bit [2:0] am;
    am = hit_ack ? low_mask(m_pend) : 3'b000;
    check({tag, "_btn"}, int'(bt), int'(m_stable));
    check({tag, "_press"}, int'(pr), int'(m_press));
    check({tag, "_valid"}, int'(v), int'(m_pend != 0));
    if (m_pend != 0) check({tag, "_id"}, int'(id), low_id(m_pend));
    check({tag, "_drop"}, int'(dr), int'((m_press & m_pend & ~am) != 0));
  endtask

  // A channel flips once its synchronised input (raw from two edges earlier)
  // has disagreed with the accepted level for D edges since the last flip.
  task automatic model_edge(input logic r, input logic [2:0] raw, input logic a);
    bit [2:0] am, npend, npress;
    bit       diff;
    edge_n++;
    if (r) begin
      rh[edge_n % 64] = 3'b000;
      rh[(edge_n - 1) % 64] = 3'b000;
      for (int i = 0; i < 3; i++) last_t[i] = edge_n;
      m_stable = 0; m_press = 0; m_pend = 0;
    end else begin
      rh[edge_n % 64] = raw;
      am     = a ? low_mask(m_pend) : 3'b000;
      npend  = (m_pend & ~am) | m_press;
      npress = 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (edge_n - last_t[i] >= D) begin
          diff = 1'b1;
          for (int k = 0; k < D; k++)
            if (rh[(edge_n - 2 - k) % 64][i] == m_stable[i]) diff = 1'b0;
          if (diff) begin
            m_stable[i] = ~m_stable[i];
            last_t[i]   = edge_n;
            npress[i]   = m_stable[i];
          end
        end
      end
      m_pend  = npend;
      m_press = npress;
    end
  endtask

  task automatic step(input logic r, input logic [2:0] raw, input logic a);
    rst = r; btn_raw = raw; hit_ack = a;
    @(negedge clk);
    check_inst("main", {btn3, btn2, btn1}, press, hit_valid, hit_id, hit_drop);
    check_inst("al", {al_btn3, al_btn2, al_btn1}, al_press, al_hit_valid, al_hit_id, al_hit_drop);
    s_btn = {btn3, btn2, btn1}; s_press = press; s_valid = hit_valid; s_id = hit_id; s_drop = hit_drop;
    if (hit_drop) drop_cnt++;
    if (press != 0) press_cnt++;
    @(posedge clk);
    model_edge(r, raw, a);
    #1;
  endtask

  task automatic hold(input logic [2:0] raw, input logic a, input int n);
    for (int i = 0; i < n; i++) step(1'b0, raw, a);
  endtask

  initial begin
    logic [2:0] rraw;
    rst = 1'b1; btn_raw = 3'b000; hit_ack = 1'b0;
    @(posedge clk);
    model_edge(1'b1, 3'b000, 1'b0);
    #1;

    // Reset with all buttons held, release, then drain with constant ack.
    for (int i = 0; i < 14; i++)
      tbl[i] = '{logic'(i < 3), 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0};
    tbl[9].e_btn = 3'b111; tbl[9].e_press = 3'b111;
    for (int i = 10; i < 14; i++) tbl[i].e_btn = 3'b111;
    tbl[10].e_valid = 1'b1; tbl[10].e_id = 2'd0;
    tbl[11].e_valid = 1'b1; tbl[11].e_id = 2'd1;
    tbl[12].e_valid = 1'b1; tbl[12].e_id = 2'd2;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].raw, tbl[i].a);
      check($sformatf("tbl%0d_btn", i), int'(s_btn), int'(tbl[i].e_btn));
      check($sformatf("tbl%0d_press", i), int'(s_press), int'(tbl[i].e_press));
      check($sformatf("tbl%0d_valid", i), int'(s_valid), int'(tbl[i].e_valid));
      if (tbl[i].e_valid) check($sformatf("tbl%0d_id", i), int'(s_id), int'(tbl[i].e_id));
      check($sformatf("tbl%0d_drop", i), int'(s_drop), int'(tbl[i].e_drop));
    end

    // Glitch of 3 cycles is rejected; 4+ cycles is accepted.
    hold(3'b000, 1'b1, 10);
    press_cnt = 0;
    hold(3'b010, 1'b0, 3);
    hold(3'b000, 1'b0, 8);
    check("glitch_btn2", int'(s_btn[1]), 0);
    check("glitch_valid", int'(s_valid), 0);
    check("glitch_press_cnt", press_cnt, 0);
    hold(3'b010, 1'b0, 6);
    step(1'b0, 3'b010, 1'b0);
    check("accept_btn", int'(s_btn), 2);
    check("accept_press", int'(s_press), 2);
    step(1'b0, 3'b010, 1'b1);
    check("accept_id", int'(s_id), 1);
    step(1'b0, 3'b010, 1'b0);
    check("accept_acked", int'(s_valid), 0);
    check("accept_press_cnt", press_cnt, 1);

    // Handshake hold for button 3.
    hold(3'b000, 1'b0, 8);
    hold(3'b100, 1'b0, 20);
    check("hold_valid", int'(s_valid), 1);
    check("hold_id", int'(s_id), 2);
    step(1'b0, 3'b100, 1'b1);
    step(1'b0, 3'b100, 1'b0);
    check("hold_acked", int'(s_valid), 0);

    // Coalesce: second press before any ack drops once; one ack empties.
    hold(3'b000, 1'b0, 8);
    hold(3'b001, 1'b0, 8);
    hold(3'b000, 1'b0, 8);
    drop_cnt = 0;
    hold(3'b001, 1'b0, 8);
    check("coalesce_drop_cnt", drop_cnt, 1);
    check("coalesce_id", int'(s_id), 0);
    step(1'b0, 3'b001, 1'b1);
    step(1'b0, 3'b001, 1'b0);
    check("coalesce_empty", int'(s_valid), 0);

    // Press landing in the same cycle as the ack of the same button.
    hold(3'b000, 1'b0, 8);
    hold(3'b001, 1'b0, 8);
    hold(3'b000, 1'b0, 8);
    hold(3'b001, 1'b0, 6);
    step(1'b0, 3'b001, 1'b1);
    check("ackpress_press", int'(s_press), 1);
    check("ackpress_drop", int'(s_drop), 0);
    step(1'b0, 3'b001, 1'b0);
    check("ackpress_valid", int'(s_valid), 1);
    check("ackpress_id", int'(s_id), 0);
    step(1'b0, 3'b001, 1'b1);

    // Bouncy release of button 2.
    hold(3'b010, 1'b1, 8);
    press_cnt = 0;
    hold(3'b000, 1'b1, 2);
    hold(3'b010, 1'b1, 2);
    hold(3'b000, 1'b1, 2);
    hold(3'b010, 1'b1, 2);
    hold(3'b000, 1'b1, 6);
    check("bounce_btn2_held", int'(s_btn[1]), 1);
    step(1'b0, 3'b000, 1'b1);
    check("bounce_btn2_fell", int'(s_btn[1]), 0);
    check("bounce_press_cnt", press_cnt, 0);

    // Reset mid-stream with inverted-idle inputs, then random traffic.
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b0);
    rraw = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) rraw[b] = ~rraw[b];
      step(logic'($urandom_range(0, 399) == 0), rraw, logic'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Upstream input stage for the Zombie game logic and matrix_generate.
- Takes the three raw punch buttons, then synchronises, debounces and edge-detects each one.
- Outputs clean level signals btn1/btn2/btn3 for the existing consumers.
- Also provides a sticky hit-event queue with a valid/ack handshake, so the slower game-clock logic never misses a one-cycle press.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a changed input must hold before it is accepted (10 ms at 50 MHz); legal range 2 to 2^CNT_W.
- CNT_W, 19, width of each debounce counter.
- ACTIVE_LOW, 0, 1 = raw buttons read 0 when pressed; inverted before synchronisation.

Ports:
- clk  in  1  system clock (undivided board clock); single clock domain.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  3  asynchronous pushbutton inputs; bit0 = button 1.
- btn1  out  1  debounced level, button 1 (1 = pressed).
- btn2  out  1  debounced level, button 2.
- btn3  out  1  debounced level, button 3.
- press  out  3  one-cycle pulse on each debounced rising edge.
- hit_valid  out  1  at least one press is pending.
- hit_id  out  2  pending button index 0..2; valid only while hit_valid=1.
- hit_ack  in  1  consumer accepts the current hit_id.
- hit_drop  out  1  one-cycle pulse when a press arrives for a button whose pending bit is already set.

Behaviour:
- Reset (rst high at a clk edge):
  - Synchroniser flops, stable states, counters and pending bits clear to 0.
  - All outputs read 0.
  - Reset applies mid-debounce and mid-handshake alike; a pending hit is discarded.
- Input path:
  - When ACTIVE_LOW=1, btn_raw is inverted first.
  - Each bit then passes through a two-flop synchroniser (s1, s2).
- Per-channel debounce:
  - If s2 equals stable, the counter is cleared.
  - If s2 differs from stable and counter equals DEBOUNCE_CYCLES-1, stable toggles and the counter clears.
  - Otherwise the counter increments.
  - A single cycle of agreement anywhere in the window restarts the count, so a glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Release is debounced identically.
- Latency:
  - Raw change set up before edge 1 and held: stable changes at edge DEBOUNCE_CYCLES+2. Example: DEBOUNCE_CYCLES=4 gives edge 6.
  - press[i] asserts for exactly the one cycle after stable[i] rises.
  - Release generates no pulse.
- Level outputs: btn1/btn2/btn3 = stable[0..2], registered.
- Pending queue:
  - pending[i] sets on press[i].
  - Arbitration is fixed priority, lowest index first: hit_id = index of the lowest set pending bit.
  - hit_valid = OR of pending; both outputs are combinational from the registered pending bits.
- Handshake:
  - hit_ack sampled high while hit_valid=1 clears pending[hit_id] at that edge.
  - hit_ack while hit_valid=0 is ignored.
  - hit_valid/hit_id hold stable until acked.
  - The consumer may hold hit_ack high; one hit is consumed per cycle.
- Simultaneous events:
  - press[i] in the same cycle as an ack of i: pending[i] stays set, so the new press is preserved.
  - press[i] while pending[i]=1 and not being acked: hits coalesce and hit_drop pulses for 1 cycle.
  - Multiple presses in the same cycle all set their bits; they are served in index order.
- Counter width:
  - CNT_W must satisfy 2^CNT_W >= DEBOUNCE_CYCLES; an elaboration-time check flags violations.
  - Counters never wrap, because they clear on toggle.

Decomposition:
- Shared package game_pkg holds:
  - BTN_NUM=3.
  - Hit-id constants HIT_BTN1=0, HIT_BTN2=1, HIT_BTN3=2.
  - Default DEBOUNCE_CYCLES.
- One sub-module, btn_debounce (single channel):
  - Contains the synchroniser, counter, stable flop and rising-edge pulse.
  - Instantiated BTN_NUM times.
- The pending register, arbiter and handshake live in btn_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, ACTIVE_LOW=0 unless stated):
- Reset: hold rst 3 cycles with btn_raw=3'b111 -> all outputs 0 during reset. After release, btn1..3 rise at edge 6 after rst falls, press=3'b111 for 1 cycle, and hit_id sequence is 0,1,2 under constant hit_ack=1.
- Glitch rejection: btn_raw[1] high for 3 cycles, then low -> btn2 stays 0, press=0, hit_valid=0. The same input held 4+ cycles gives btn2=1 at edge 6 and press=3'b010 once.
- Handshake hold: press button 3 with hit_ack=0 for 20 cycles -> hit_valid=1 and hit_id=2 constant. Pulse hit_ack 1 cycle -> hit_valid=0 on the next cycle.
- Coalesce and drop: press button 1, release, then press again before any ack -> hit_drop pulses once and a single ack empties the queue. A second press landing in the same cycle as the ack -> hit_valid remains 1 with hit_id=0.
- Bouncy release: button 2 held, then raw toggles 1-0-1-0 with 2-cycle spacing before settling low -> btn2 falls exactly 6 edges after the final settle and no extra press pulses occur.
- ACTIVE_LOW=1: btn_raw idles at 3'b111 through reset -> no press. Driving bit0 low for 4+ cycles -> btn1=1 and hit_id=0.
